// File: rtl/isp_1bit_morph.sv
// 3x3 binary morphology stage (bypass / erode / dilate / majority) on a raster
// stream of 1-bit pixels, with two line buffers and a fixed 2-cycle latency.
module isp_1bit_morph #(
  parameter int   IMG_W  = 640,
  parameter int   IMG_H  = 480,
  parameter int   MAJ_TH = 5,
  parameter logic BORDER = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic        sof,
  input  logic [1:0]  mode,
  input  logic        img_1bit_in,
  output logic        morph_wr_en,
  output logic        img_1bit_out,
  output logic [15:0] morph_rgb565
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [3:0]    MAJ_TH_4 = 4'(MAJ_TH);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_MAJ    = 2'd3
  } mode_e;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  mode_e         r_mode_q;

  logic          r_buf1 [IMG_W];
  logic          r_buf2 [IMG_W];

  logic [2:0]    r_win0;
  logic [2:0]    r_win1;
  logic [2:0]    r_win2;
  logic          r_border_s1;
  mode_e         r_mode_s1;
  logic          r_vld_s1;

  logic          r_vld_s2;
  logic          r_out;
  logic [15:0]   r_rgb;

  logic [CW-1:0] w_pos_col;
  logic [RW-1:0] w_pos_row;
  logic [CW-1:0] w_nxt_col;
  logic [RW-1:0] w_nxt_row;
  logic          w_frame_start;
  mode_e         w_mode_eff;
  logic [2:0]    w_col_new;
  logic [8:0]    w_win9;
  logic [3:0]    w_ones;
  logic          w_result;

  // sof overrides the counters so the pixel accepted alongside it is (0,0)
  assign w_pos_col = sof ? '0 : r_col;
  assign w_pos_row = sof ? '0 : r_row;

  always_comb begin
    w_nxt_col = w_pos_col + CW'(1);
    w_nxt_row = w_pos_row;
    if (w_pos_col == COL_LAST) begin
      w_nxt_col = '0;
      w_nxt_row = (w_pos_row == ROW_LAST) ? '0 : w_pos_row + RW'(1);
    end
  end

  assign w_frame_start = sof | (wr_en & (w_pos_col == '0) & (w_pos_row == '0));
  assign w_mode_eff    = w_frame_start ? mode_e'(mode) : r_mode_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_mode_q <= MODE_BYPASS;
    end else begin
      if (wr_en) begin
        r_col <= w_nxt_col;
        r_row <= w_nxt_row;
      end else if (sof) begin
        r_col <= '0;
        r_row <= '0;
      end
      if (w_frame_start) begin
        r_mode_q <= mode_e'(mode);
      end
    end
  end

  // Line buffers carry no reset; rows 0-1 are forced to BORDER before any read matters
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      r_buf2[w_pos_col] <= r_buf1[w_pos_col];
      r_buf1[w_pos_col] <= img_1bit_in;
    end
  end

  // Column bits ordered {row-2, row-1, row}
  assign w_col_new = {r_buf2[w_pos_col], r_buf1[w_pos_col], img_1bit_in};

  // Mode travels with each pixel so a later sof cannot alter pixels in flight
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_win0      <= '0;
      r_win1      <= '0;
      r_win2      <= '0;
      r_border_s1 <= 1'b0;
      r_mode_s1   <= MODE_BYPASS;
      r_vld_s1    <= 1'b0;
    end else begin
      r_vld_s1 <= wr_en;
      if (wr_en) begin
        r_win0      <= r_win1;
        r_win1      <= r_win2;
        r_win2      <= w_col_new;
        r_border_s1 <= (w_pos_row < RW'(2)) || (w_pos_col < CW'(2));
        r_mode_s1   <= w_mode_eff;
      end
    end
  end

  assign w_win9 = {r_win0, r_win1, r_win2};

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < 9; i++) begin
      w_ones = w_ones + {3'b000, w_win9[i]};
    end
  end

  always_comb begin
    w_result = BORDER;
    if (!r_border_s1) begin
      case (r_mode_s1)
        MODE_BYPASS: w_result = r_win1[1];
        MODE_ERODE:  w_result = &w_win9;
        MODE_DILATE: w_result = |w_win9;
        MODE_MAJ:    w_result = (w_ones >= MAJ_TH_4);
        default:     w_result = BORDER;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld_s2 <= 1'b0;
      r_out    <= 1'b0;
      r_rgb    <= 16'h0000;
    end else begin
      r_vld_s2 <= r_vld_s1;
      if (r_vld_s1) begin
        r_out <= w_result;
        r_rgb <= {16{w_result}};
      end
    end
  end

  assign morph_wr_en  = r_vld_s2;
  assign img_1bit_out = r_out;
  assign morph_rgb565 = r_rgb;

endmodule

// File: tb/tb_isp_1bit_morph.sv
// Self-checking bench for isp_1bit_morph: directed frame table, hand sequences
// for mode latch / sof / reset, and randomized traffic against an image-array model.
module tb_isp_1bit_morph;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        sof = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        img_1bit_in = 1'b0;
  logic        morph_wr_en;
  logic        img_1bit_out;
  logic [15:0] morph_rgb565;

  isp_1bit_morph #(.IMG_W(W), .IMG_H(H), .MAJ_TH(TH), .BORDER(1'b0)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_en        (wr_en),
    .sof          (sof),
    .mode         (mode),
    .img_1bit_in  (img_1bit_in),
    .morph_wr_en  (morph_wr_en),
    .img_1bit_out (img_1bit_out),
    .morph_rgb565 (morph_rgb565)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: image indexed by position, raster position, latched mode
  logic       m_img [H][W];
  int         m_row, m_col;
  logic [1:0] m_mode_q;
  logic       h0_v, h0_d, h1_v, h1_d;
  logic       m_last;

  logic [47:0] cap;
  int          out_idx;

  typedef struct {
    logic [1:0]  md;
    logic [47:0] frame;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs [7];

  localparam logic [47:0] ONES   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SINGLE = 48'h00_00_08_00_00_00;
  localparam logic [47:0] E_FULL = 48'hFC_FC_FC_FC_00_00;
  localparam logic [47:0] D_SING = 48'h38_38_38_00_00_00;
  localparam logic [47:0] B_SING = 48'h00_10_00_00_00_00;

  task automatic cmp(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_mode_q = 2'd0;
    h0_v = 0; h0_d = 0; h1_v = 0; h1_d = 0;
    m_last = 0;
  endtask

  task automatic model_accept(input logic wr, input logic s, input logic [1:0] md, input logic px);
    int pr, pc, ones;
    logic res;
    res = 1'b0;
    pr = s ? 0 : m_row;
    pc = s ? 0 : m_col;
    if (s || (wr && pr == 0 && pc == 0)) m_mode_q = md;
    if (wr) begin
      m_img[pr][pc] = px;
      if (pr >= 2 && pc >= 2) begin
        ones = 0;
        for (int r = pr - 2; r <= pr; r++)
          for (int c = pc - 2; c <= pc; c++)
            ones += int'(m_img[r][c]);
        case (m_mode_q)
          2'd0: res = m_img[pr-1][pc-1];
          2'd1: res = (ones == 9);
          2'd2: res = (ones > 0);
          default: res = (ones >= TH);
        endcase
      end
      if (pc == W - 1) begin
        pc = 0;
        pr = (pr == H - 1) ? 0 : pr + 1;
      end else begin
        pc++;
      end
      m_row = pr; m_col = pc;
    end else if (s) begin
      m_row = 0; m_col = 0;
    end
    h1_v = h0_v; h1_d = h0_d;
    h0_v = wr;   h0_d = res;
  endtask

  task automatic check_outputs();
    cmp("valid", 48'(morph_wr_en), 48'(h1_v));
    if (h1_v) m_last = h1_d;
    cmp("pixel", 48'(img_1bit_out), 48'(m_last));
    cmp("rgb565", 48'(morph_rgb565), m_last ? 48'hFFFF : 48'h0);
    if (morph_wr_en === 1'b1) begin
      if (out_idx < 48) cap[out_idx] = img_1bit_out;
      out_idx++;
    end
  endtask

  // Called at a negedge: check, drive, advance one clock, return at next negedge
  task automatic step(input logic wr, input logic s, input logic [1:0] md, input logic px);
    check_outputs();
    wr_en = wr; sof = s; mode = md; img_1bit_in = px;
    model_accept(wr, s, md, px);
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_reset(input int n);
    sys_rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_en = 1'($urandom); sof = 1'($urandom); mode = 2'($urandom); img_1bit_in = 1'($urandom);
      #1;
      cmp("rst_valid", 48'(morph_wr_en), 48'h0);
      cmp("rst_pixel", 48'(img_1bit_out), 48'h0);
      cmp("rst_rgb565", 48'(morph_rgb565), 48'h0);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    model_reset();
    out_idx = 0;
    sys_rst_n = 1'b1;
  endtask

  task automatic run_frame(input logic [1:0] md, input logic [47:0] fr,
                           input int chg_at, input logic [1:0] md2);
    out_idx = 0;
    cap = '0;
    for (int i = 0; i < 48; i++)
      step(1'b1, 1'b0, (chg_at >= 0 && i >= chg_at) ? md2 : md, fr[i]);
    step(1'b0, 1'b0, md, 1'b0);
    step(1'b0, 1'b0, md, 1'b0);
  endtask

  initial begin
    vecs[0] = '{md: 2'd1, frame: ONES,   exp: E_FULL};
    vecs[1] = '{md: 2'd2, frame: SINGLE, exp: D_SING};
    vecs[2] = '{md: 2'd1, frame: SINGLE, exp: 48'h0};
    vecs[3] = '{md: 2'd3, frame: SINGLE, exp: 48'h0};
    vecs[4] = '{md: 2'd0, frame: SINGLE, exp: B_SING};
    vecs[5] = '{md: 2'd3, frame: ONES,   exp: E_FULL};
    vecs[6] = '{md: 2'd0, frame: ONES,   exp: E_FULL};

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        m_img[r][c] = 1'b0;
    model_reset();
    out_idx = 0;
    cap = '0;

    @(negedge sys_clk);
    do_reset(4);

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].md, vecs[v].frame, -1, 2'd0);
      cmp($sformatf("table%0d_count", v), 48'(out_idx), 48'd48);
      cmp($sformatf("table%0d_image", v), cap, vecs[v].exp);
    end

    // Mode change mid-frame only takes effect on the following frame
    run_frame(2'd1, SINGLE, 24, 2'd2);
    cmp("modechg_frame_image", cap, 48'h0);
    run_frame(2'd2, SINGLE, -1, 2'd0);
    cmp("modechg_next_image", cap, D_SING);

    // Idle sof at (2,5) restarts the raster
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 2'd1, 1'b1);
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    run_frame(2'd1, ONES, -1, 2'd0);
    cmp("sof_count", 48'(out_idx), 48'd48);
    cmp("sof_image", cap, E_FULL);

    // Randomized traffic: gaps, sof pulses with and without wr_en, mode churn
    for (int i = 0; i < 800; i++) begin
      step(1'(($urandom % 4) != 0), 1'(($urandom % 70) == 0),
           2'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0);

    // Reset at (4,6) with erode latched; next frame must dilate from a clean start
    for (int i = 0; i < 38; i++) step(1'b1, 1'b0, 2'd1, 1'($urandom));
    do_reset(3);
    run_frame(2'd2, SINGLE, -1, 2'd0);
    cmp("postrst_count", 48'(out_idx), 48'd48);
    cmp("postrst_image", cap, D_SING);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
